// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared types for the counter bank and its channels
package counter_bank_pkg;
  typedef enum logic [1:0] {ACT_HOLD, ACT_COUNT, ACT_LOAD, ACT_RESET} act_e;
  function automatic act_e pick_act(logic rst, logic load, logic enable);
    return rst ? ACT_RESET : load ? ACT_LOAD : enable ? ACT_COUNT : ACT_HOLD;
  endfunction
endpackage

// File: rtl/counter_bank.vh
// counter_bank.vh: mode constants and all-ones helper shared by the bank and its channels
localparam int COUNTER_MODE_WRAP = 0;
localparam int COUNTER_MODE_SATURATE = 1;
`ifndef COUNTER_BANK_ONES
`define COUNTER_BANK_ONES(w) {(w){1'b1}}
`endif

// File: rtl/counter_bank_channel.sv
// counter_bank_channel: one up-counter with load, wrap/saturate terminal handling, tc pulse and toggle
module counter_bank_channel
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             toggle_o,
  output logic             tc_next_o
);
  `include "counter_bank.vh"
  localparam logic wrap = SATURATE == COUNTER_MODE_WRAP;
  act_e act;
  logic [WIDTH:0] inc;
  logic [WIDTH-1:0] count_n;
  logic at_limit, at_ones, stop, hit;
  always_comb begin
    act = pick_act(rst_i, load_i, enable_i);
    inc = {1'b0, count_o} + {{WIDTH{1'b0}}, 1'b1};
    at_limit = count_o == limit_i;
    at_ones = count_o == `COUNTER_BANK_ONES(WIDTH);
    stop = wrap ? at_limit : at_limit || at_ones;
    hit = wrap ? at_limit : !stop && inc[WIDTH-1:0] == limit_i;
    // a count above the limit rolls over through zero silently in wrap mode
    count_n = wrap ? (at_limit || inc[WIDTH] ? '0 : inc[WIDTH-1:0]) : (stop ? count_o : inc[WIDTH-1:0]);
    tc_next_o = act == ACT_COUNT && hit;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
      tc_o <= 1'b0;
      toggle_o <= 1'b0;
    end else begin
      count_o <= act == ACT_LOAD ? data_i : act == ACT_COUNT ? count_n : count_o;
      tc_o <= tc_next_o;
      toggle_o <= toggle_o ^ tc_next_o;
    end
  end
endmodule

// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent counters sharing a terminal value, with an aligned any-tc flag
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS-1:0]       enable_i,
  input  logic [CHANNELS-1:0]       load_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0]          limit_i,
  output logic [CHANNELS*WIDTH-1:0] count_o,
  output logic [CHANNELS-1:0]       tc_o,
  output logic [CHANNELS-1:0]       toggle_o,
  output logic                      any_tc_o
);
  `include "counter_bank.vh"
  localparam int mode = SATURATE != 0 ? COUNTER_MODE_SATURATE : COUNTER_MODE_WRAP;
  logic [CHANNELS-1:0] tc_next;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    counter_bank_channel #(
      .WIDTH(WIDTH),
      .SATURATE(mode)
    ) u_ch (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .enable_i(enable_i[c]),
      .load_i(load_i[c]),
      .data_i(data_i[c*WIDTH +: WIDTH]),
      .limit_i(limit_i),
      .count_o(count_o[c*WIDTH +: WIDTH]),
      .tc_o(tc_o[c]),
      .toggle_o(toggle_o[c]),
      .tc_next_o(tc_next[c])
    );
  end
  // registered from the next-state tc vector so it lands on the same cycle as tc_o
  always_ff @(posedge clk_i) begin
    if (rst_i) any_tc_o <= 1'b0;
    else any_tc_o <= |tc_next;
  end
endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: scoreboard bench for wrap and saturate counter banks
module tb_counter_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [3:0] en, ld;
  logic [31:0] data;
  logic [7:0] lim;
  logic [31:0] count_w, count_s;
  logic [3:0] tc_w, tc_s, tog_w, tog_s;
  logic any_w, any_s;

  counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) dut_w (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .load_i(ld), .data_i(data), .limit_i(lim),
    .count_o(count_w), .tc_o(tc_w), .toggle_o(tog_w), .any_tc_o(any_w));
  counter_bank #(.WIDTH(8), .CHANNELS(4), .SATURATE(1)) dut_s (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .load_i(ld), .data_i(data), .limit_i(lim),
    .count_o(count_s), .tc_o(tc_s), .toggle_o(tog_s), .any_tc_o(any_s));

  typedef struct {
    int cyc;
    bit sat;
    int ch;
    logic [7:0] count;
    logic tc;
    logic tog;
    logic any;
    string name;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  logic [7:0] a_cnt;
  logic a_tc, a_tog, a_any;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input bit sat, input int ch, input logic [7:0] count, input logic tc, input logic tog, input logic any, input string name);
    sb.push_back('{cyc + 1, sat, ch, count, tc, tog, any, name});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input string field, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s %s cycle %0d: got %h expected %h", name, field, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      if (cur.cyc != cyc) begin
        checks++;
        fails++;
        $display("FAIL %s stale entry: due cycle %0d, now %0d", cur.name, cur.cyc, cyc);
      end else begin
        a_cnt = cur.sat ? count_s[cur.ch*8 +: 8] : count_w[cur.ch*8 +: 8];
        a_tc = cur.sat ? tc_s[cur.ch] : tc_w[cur.ch];
        a_tog = cur.sat ? tog_s[cur.ch] : tog_w[cur.ch];
        a_any = cur.sat ? any_s : any_w;
        check(cur.name, "count", a_cnt, cur.count);
        check(cur.name, "tc", {7'd0, a_tc}, {7'd0, cur.tc});
        check(cur.name, "toggle", {7'd0, a_tog}, {7'd0, cur.tog});
        check(cur.name, "any_tc", {7'd0, a_any}, {7'd0, cur.any});
      end
    end
  end

  logic [7:0] seq3 [7];

  initial begin
    seq3 = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    rst = 1'b1; en = 4'hF; ld = 4'hF; data = 32'h44332211; lim = 8'hFF;
    for (int r = 0; r < 3; r++) begin
      for (int ch = 0; ch < 4; ch++) push_exp(0, ch, 8'd0, 0, 0, 0, "reset");
      push_exp(1, 0, 8'd0, 0, 0, 0, "reset_sat");
      tick;
    end
    rst = 1'b0; ld = 4'h0;
    for (int k = 1; k <= 3; k++) begin
      for (int ch = 0; ch < 4; ch++) push_exp(0, ch, 8'(k), 0, 0, 0, "release");
      tick;
    end
    rst = 1'b1; tick; rst = 1'b0;
    en = 4'b0001; lim = 8'd5;
    for (int k = 1; k <= 5; k++) begin
      push_exp(0, 0, 8'(k), 0, 0, 0, "wrap");
      tick;
    end
    push_exp(0, 0, 8'd0, 1, 1, 1, "wrap_tc"); tick;
    en = 4'b0000;
    push_exp(0, 0, 8'd0, 0, 1, 0, "wrap_hold"); tick;
    ld = 4'b0010; data = 32'h0000FE00;
    push_exp(0, 1, 8'hFE, 0, 0, 0, "load_fe"); tick;
    ld = 4'b0000; en = 4'b0010;
    for (int i = 0; i < 7; i++) begin
      push_exp(0, 1, seq3[i], 0, 0, 0, "above_limit");
      tick;
    end
    push_exp(0, 1, 8'd0, 1, 1, 1, "above_limit_tc"); tick;
    rst = 1'b1; en = 4'b0000; tick; rst = 1'b0;
    lim = 8'd3; en = 4'b0001;
    push_exp(1, 0, 8'd1, 0, 0, 0, "sat"); tick;
    push_exp(1, 0, 8'd2, 0, 0, 0, "sat"); tick;
    push_exp(1, 0, 8'd3, 1, 1, 1, "sat_arrive"); tick;
    for (int i = 0; i < 3; i++) begin
      push_exp(1, 0, 8'd3, 0, 1, 0, "sat_hold");
      tick;
    end
    ld = 4'b0001; data = 32'h0;
    push_exp(1, 0, 8'd0, 0, 1, 0, "sat_load"); tick;
    ld = 4'b0000;
    push_exp(1, 0, 8'd1, 0, 1, 0, "sat_restart"); tick;
    push_exp(1, 0, 8'd2, 0, 1, 0, "sat_restart"); tick;
    push_exp(1, 0, 8'd3, 1, 0, 1, "sat_rearrive"); tick;
    rst = 1'b1; en = 4'b0000; tick; rst = 1'b0;
    ld = 4'b0100; en = 4'b0100; data = 32'h00100000;
    push_exp(0, 2, 8'h10, 0, 0, 0, "load_wins"); tick;
    ld = 4'b0000; en = 4'b1001; lim = 8'd2;
    push_exp(0, 0, 8'd1, 0, 0, 0, "simul_pre"); push_exp(0, 3, 8'd1, 0, 0, 0, "simul_pre"); tick;
    push_exp(0, 0, 8'd2, 0, 0, 0, "simul_pre"); push_exp(0, 3, 8'd2, 0, 0, 0, "simul_pre"); tick;
    push_exp(0, 0, 8'd0, 1, 1, 1, "simul_ch0");
    push_exp(0, 1, 8'd0, 0, 0, 1, "simul_ch1");
    push_exp(0, 2, 8'h10, 0, 0, 1, "simul_ch2");
    push_exp(0, 3, 8'd0, 1, 1, 1, "simul_ch3");
    tick;
    rst = 1'b1; en = 4'b0000; tick; rst = 1'b0;
    lim = 8'd0; en = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      push_exp(0, 0, 8'd0, 1, (i % 2) == 0, 1, "limit0");
      tick;
    end
    rst = 1'b1;
    for (int ch = 0; ch < 4; ch++) push_exp(0, ch, 8'd0, 0, 0, 0, "mid_reset");
    tick;
    rst = 1'b0; en = 4'b0000;
    tick; tick;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
